alu_exec_mc: RTL and testbench



---
 rtl/alu_defs.sv | 26 ++
 rtl/muldiv_iter.sv | 72 +++++++
 rtl/alu_exec_mc.sv | 160 ++++++++++++++++
 tb/tb_alu_exec_mc.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// Opcode encodings and FSM state type shared by the execute-stage ALU.
package alu_defs;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for opcodes that go through the iterative mul/div datapath.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared shift-add multiplier / restoring divider, one step per cycle.
// acc holds {high, low}: for MUL {partial product, remaining multiplier},
// for DIV {partial remainder, quotient being shifted in}.
// res_lo/res_hi expose the value the accumulator takes after the current
// step, so the parent can capture the final answer on the last step edge.
module muldiv_iter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] res_lo,
    output logic [DATA_WIDTH-1:0] res_hi
);

    localparam int W = DATA_WIDTH;

    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_nxt;
    logic [W-1:0]   divisor;
    logic           mode_div;

    logic [W-1:0]   acc_hi;
    logic [W-1:0]   acc_lo;
    logic [W:0]     madd;
    logic [W:0]     rem_sh;
    logic [W-1:0]   trial;

    assign acc_hi = acc[2*W-1:W];
    assign acc_lo = acc[W-1:0];

    // One multiply or divide step computed from the current accumulator.
    always_comb begin
        madd    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, divisor} : {(W+1){1'b0}});
        rem_sh  = acc[2*W-1:W-1];
        // Only used when rem_sh >= divisor, so the difference fits in W bits.
        trial   = rem_sh[W-1:0] - divisor;
        acc_nxt = acc;
        if (mode_div) begin
            if (rem_sh >= {1'b0, divisor}) begin
                acc_nxt = {trial, acc_lo[W-2:0], 1'b1};
            end else begin
                acc_nxt = {rem_sh[W-1:0], acc_lo[W-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {madd, acc_lo[W-1:1]};
        end
    end

    // Accumulator, divisor/multiplicand and mode registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            divisor  <= '0;
            mode_div <= 1'b0;
        end else if (load) begin
            acc      <= {{W{1'b0}}, a};
            divisor  <= b;
            mode_div <= is_div;
        end else if (step) begin
            acc      <= acc_nxt;
        end
    end

    assign res_lo = acc_nxt[W-1:0];
    assign res_hi = acc_nxt[2*W-1:W];

endmodule

// File: rtl/alu_exec_mc.sv
// Execute-stage ALU: single-cycle logic/add/sub/shift, iterative unsigned
// MUL/DIV. Results and flags are registered and held until the next completion.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start
//   CALC    | iterative MUL/DIV running, busy=1, counter DATA_WIDTH-1..0
//   DONE    | done pulse; a new start is accepted here as well
module alu_exec_mc
    import alu_defs::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic                  done,
    output logic                  busy,
    output logic                  zero,
    output logic                  ovf,
    output logic                  div_zero
);

    localparam int W    = DATA_WIDTH;
    localparam int SH_W = $clog2(DATA_WIDTH);
    localparam int MSB  = DATA_WIDTH - 1;

    state_t           state;
    logic [SH_W-1:0]  counter;
    logic             b_zero_q;

    logic             accept;
    logic             iter_op;
    logic             md_load;
    logic             md_step;
    logic [W-1:0]     md_lo;
    logic [W-1:0]     md_hi;

    logic [W-1:0]     sum;
    logic [W-1:0]     diff;
    logic [SH_W-1:0]  shamt;
    logic [W-1:0]     sc_result;
    logic             sc_ovf;
    logic             sc_defined;
    logic             sc_zero;

    assign accept  = start && (state != ST_CALC);
    assign iter_op = is_iterative(alu_op);
    assign md_load = accept && iter_op;
    assign md_step = (state == ST_CALC);

    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;
    assign shamt = op_b[SH_W-1:0];

    // Single-cycle result and flags from the operands presented at acceptance.
    always_comb begin
        sc_result  = '0;
        sc_ovf     = 1'b0;
        sc_defined = 1'b1;
        case (alu_op)
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            OP_AND:  sc_result = op_a & op_b;
            OP_OR:   sc_result = op_a | op_b;
            OP_XOR:  sc_result = op_a ^ op_b;
            OP_SLL:  sc_result = op_a << shamt;
            OP_SRL:  sc_result = op_a >> shamt;
            OP_SRA:  sc_result = W'($signed(op_a) >>> shamt);
            default: sc_defined = 1'b0;
        endcase
        // Undefined opcodes report all flags clear, including zero.
        sc_zero = sc_defined && (sc_result == '0);
    end

    muldiv_iter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .load   (md_load),
        .step   (md_step),
        .is_div (alu_op == OP_DIV),
        .a      (op_a),
        .b      (op_b),
        .res_lo (md_lo),
        .res_hi (md_hi)
    );

    // Sequencing FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            counter   <= '0;
            b_zero_q  <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (iter_op) begin
                            state    <= ST_CALC;
                            busy     <= 1'b1;
                            counter  <= SH_W'(W - 1);
                            b_zero_q <= (alu_op == OP_DIV) && (op_b == '0);
                        end else begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            result    <= sc_result;
                            result_hi <= '0;
                            zero      <= sc_zero;
                            ovf       <= sc_ovf;
                            div_zero  <= 1'b0;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (counter == '0) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= md_lo;
                        result_hi <= md_hi;
                        zero      <= (md_lo == '0);
                        ovf       <= 1'b0;
                        div_zero  <= b_zero_q;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_mc.sv
// Self-checking bench for alu_exec_mc: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_exec_mc;
    import alu_defs::*;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    alu_op = 4'd0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          done;
    logic          busy;
    logic          zero;
    logic          ovf;
    logic          div_zero;

    int checks = 0;
    int errors = 0;

    alu_exec_mc #(.DATA_WIDTH(W), .OP_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .result    (result),
        .result_hi (result_hi),
        .done      (done),
        .busy      (busy),
        .zero      (zero),
        .ovf       (ovf),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the opcode's definition.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [W-1:0] rh,
                                  output logic z, output logic o, output logic dz, output int lat);
        int sa, sb, full, sh;
        longint p;
        r = '0; rh = '0; z = 1'b0; o = 1'b0; dz = 1'b0; lat = 1;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(b % 16);
        full = 0;
        p = 0;
        case (op)
            4'd0: begin full = sa + sb; r = W'(full); o = (full > 32767) || (full < -32768); end
            4'd1: begin full = sa - sb; r = W'(full); o = (full > 32767) || (full < -32768); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = W'(a << sh);
            4'd6: r = a >> sh;
            4'd7: r = W'(sa >>> sh);
            4'd8: begin p = longint'(a) * longint'(b); r = W'(p); rh = W'(p >> 16); lat = W + 1; end
            4'd9: begin
                lat = W + 1;
                if (b == 0) begin r = 16'hFFFF; rh = a; dz = 1'b1; end
                else begin r = a / b; rh = a % b; end
            end
            default: ;
        endcase
        if (op <= 4'd9) z = (r == 0);
    endfunction

    // Issue one op, scramble the inputs after acceptance, wait for done.
    // lat counts cycles after the accepting edge until done is seen.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; alu_op = op; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; alu_op = 4'($urandom); op_a = W'($urandom); op_b = W'($urandom);
        lat = 0; bcnt = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({result, result_hi, done, busy, zero, ovf, div_zero} !== '0) begin
            errors++;
            $display("FAIL reset_state got r=%h rh=%h d=%b b=%b z=%b o=%b dz=%b want all 0",
                     result, result_hi, done, busy, zero, ovf, div_zero);
        end
        rst = 1'b1;
    endtask

    task automatic test_addsub();
        int lat, bc;
        run_op(OP_ADD, 16'h7FFF, 16'h0001, lat, bc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
        checks++; if (result !== 16'h8000) begin errors++; $display("FAIL add_result got %h want 8000", result); end
        checks++; if ({ovf, zero, result_hi} !== {1'b1, 1'b0, 16'h0}) begin
            errors++; $display("FAIL add_flags got ovf=%b zero=%b rh=%h want 1 0 0000", ovf, zero, result_hi); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", done); end
        checks++; if (result !== 16'h8000) begin errors++; $display("FAIL result_hold got %h want 8000", result); end
        run_op(OP_SUB, 16'd5, 16'd5, lat, bc);
        checks++; if ({lat == 1, result, zero, ovf} !== {1'b1, 16'h0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sub_zero got lat=%0d r=%h z=%b o=%b want 1 0000 1 0", lat, result, zero, ovf); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] xa, xb, oa, ob, er, erh;
        logic ez, eo, edz;
        int el;
        xa = W'($urandom); xb = W'($urandom); oa = W'($urandom); ob = W'($urandom);
        @(negedge clk);
        start = 1'b1; alu_op = OP_XOR; op_a = xa; op_b = xb;
        @(posedge clk); #1;
        alu_op = OP_SRA; op_a = 16'h8000; op_b = 16'd4;
        @(negedge clk);
        model(OP_XOR, xa, xb, er, erh, ez, eo, edz, el);
        checks++; if ({done, result} !== {1'b1, er}) begin
            errors++; $display("FAIL b2b_xor got d=%b r=%h want 1 %h", done, result, er); end
        @(posedge clk); #1;
        alu_op = OP_OR; op_a = oa; op_b = ob;
        @(negedge clk);
        checks++; if ({done, result} !== {1'b1, 16'hF800}) begin
            errors++; $display("FAIL b2b_sra got d=%b r=%h want 1 f800", done, result); end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        model(OP_OR, oa, ob, er, erh, ez, eo, edz, el);
        checks++; if ({done, result, zero} !== {1'b1, er, ez}) begin
            errors++; $display("FAIL b2b_or got d=%b r=%h z=%b want 1 %h %b", done, result, zero, er, ez); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", done); end
    endtask

    task automatic test_mul();
        int lat, bc;
        run_op(OP_MUL, 16'hFFFF, 16'hFFFF, lat, bc);
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL mul_latency got %0d want %0d", lat, W + 1); end
        checks++; if (bc !== W) begin errors++; $display("FAIL mul_busy_cycles got %0d want %0d", bc, W); end
        checks++; if ({result_hi, result} !== 32'hFFFE_0001) begin
            errors++; $display("FAIL mul_product got %h_%h want fffe_0001", result_hi, result); end
    endtask

    task automatic test_div();
        int lat, bc;
        run_op(OP_DIV, 16'd100, 16'd7, lat, bc);
        checks++; if ({lat == W + 1, result, result_hi, div_zero} !== {1'b1, 16'd14, 16'd2, 1'b0}) begin
            errors++; $display("FAIL div_100_7 got lat=%0d q=%0d r=%0d dz=%b want 17 14 2 0", lat, result, result_hi, div_zero); end
        run_op(OP_DIV, 16'd1234, 16'd0, lat, bc);
        checks++; if ({lat == W + 1, result, result_hi, div_zero} !== {1'b1, 16'hFFFF, 16'd1234, 1'b1}) begin
            errors++; $display("FAIL div_by_zero got lat=%0d q=%h r=%0d dz=%b want 17 ffff 1234 1", lat, result, result_hi, div_zero); end
    endtask

    task automatic test_busy_ignore();
        int ndone, first, lat, bc;
        logic [W-1:0] r_lo, r_hi;
        ndone = 0; first = 0; r_lo = '0; r_hi = '0;
        @(negedge clk);
        start = 1'b1; alu_op = OP_MUL; op_a = 16'd300; op_b = 16'd500;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (cyc == 3) begin start = 1'b1; alu_op = OP_ADD; op_a = 16'd1; op_b = 16'd1; end
            else start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin first = cyc; r_lo = result; r_hi = result_hi; end
            end
        end
        checks++; if (ndone !== 1 || first !== W + 1) begin
            errors++; $display("FAIL busy_ignore_done got count=%0d at=%0d want 1 at %0d", ndone, first, W + 1); end
        checks++; if ({r_hi, r_lo} !== 32'h0002_49F0) begin
            errors++; $display("FAIL busy_ignore_result got %h_%h want 0002_49f0", r_hi, r_lo); end
        run_op(4'hF, W'($urandom), W'($urandom), lat, bc);
        checks++; if ({lat == 1, result, result_hi, zero, ovf, div_zero} !== {1'b1, 32'h0, 3'b000}) begin
            errors++; $display("FAIL undef_op got lat=%0d r=%h rh=%h z=%b o=%b dz=%b want 1 0 0 0 0 0",
                               lat, result, result_hi, zero, ovf, div_zero); end
    endtask

    task automatic test_reset_mid_mul();
        int lat, bc, bad;
        run_op(OP_ADD, 16'd3, 16'd4, lat, bc);
        @(negedge clk);
        start = 1'b1; alu_op = OP_MUL; op_a = 16'd7; op_b = 16'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_mul_busy got %b want 1", busy); end
        rst = 1'b0;
        #1;
        checks++; if ({result, result_hi, done, busy, zero, ovf, div_zero} !== '0) begin
            errors++; $display("FAIL async_reset got r=%h rh=%h d=%b b=%b z=%b o=%b dz=%b want all 0",
                               result, result_hi, done, busy, zero, ovf, div_zero); end
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL post_reset_quiet got %0d bad cycles want 0", bad); end
        run_op(OP_MUL, 16'd7, 16'd9, lat, bc);
        checks++; if ({lat == W + 1, result, result_hi} !== {1'b1, 16'd63, 16'd0}) begin
            errors++; $display("FAIL mul_after_reset got lat=%0d r=%0d rh=%0d want 17 63 0", lat, result, result_hi); end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [W-1:0] a, b, er, erh;
        logic ez, eo, edz;
        int el, lat, bc;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 20));
            if (op == OP_DIV && $urandom_range(0, 5) == 0) b = '0;
            model(op, a, b, er, erh, ez, eo, edz, el);
            run_op(op, a, b, lat, bc);
            checks++; if (lat !== el) begin
                errors++; $display("FAIL rand_latency op=%0d got %0d want %0d", op, lat, el); end
            checks++; if ({result, result_hi} !== {er, erh}) begin
                errors++; $display("FAIL rand_result op=%0d a=%h b=%h got %h_%h want %h_%h", op, a, b, result_hi, result, erh, er); end
            checks++; if ({zero, ovf, div_zero} !== {ez, eo, edz}) begin
                errors++; $display("FAIL rand_flags op=%0d a=%h b=%h got z%b o%b dz%b want z%b o%b dz%b",
                                   op, a, b, zero, ovf, div_zero, ez, eo, edz); end
        end
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_back_to_back();
        test_mul();
        test_div();
        test_busy_ignore();
        test_reset_mid_mul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
